// File: rtl/mem_pkg.sv
// Shared memory-op encodings, LSU error codes and FSM states.
// Helpers: is_load(op), op_bytes(op).
package mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_t;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_RANGE      = 2'b10
  } lsu_err_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } lsu_state_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction

  function automatic logic [2:0] op_bytes(mem_op_t op);
    logic [2:0] n;
    case (op)
      LB, LBU, SB: n = 3'd1;
      LH, LHU, SH: n = 3'd2;
      default:     n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Execute-side request/response handshake plus data_memory pins.
// master: core + memory side; slave: lsu_ctrl.
interface lsu_ctrl_if;
  import mem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  mem_op_t     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_is_load;
  lsu_err_t    resp_err;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  mem_op_t     mem_fun3;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_op, req_addr,
    output req_wdata, req_rd, resp_ready,
    output mem_rdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_rd,
    input  resp_is_load, resp_err,
    input  mem_read, mem_write,
    input  mem_addr, mem_fun3, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    input  req_wdata, req_rd, resp_ready,
    input  mem_rdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_rd,
    output resp_is_load, resp_err,
    output mem_read, mem_write,
    output mem_addr, mem_fun3, mem_wdata
  );

endinterface

// File: rtl/lsu_align_check.sv
// Combinational fault check: (op, addr) -> lsu_err_t.
// Misalignment wins over out-of-range.
module lsu_align_check
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  mem_op_t     op,
  input  logic [31:0] addr,
  output lsu_err_t    err
);

  localparam logic [32:0] LIMIT = 33'(DEPTH) << 2;

  logic [31:0] mask;
  logic        misal;
  logic        oor;

  assign mask  = 32'(op_bytes(op)) - 32'd1;
  assign misal = |(addr & mask);
  assign oor   = {1'b0, addr} >= LIMIT;

  always_comb begin
    err = ERR_OK;
    if (misal)    err = ERR_MISALIGNED;
    else if (oor) err = ERR_RANGE;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of data_memory: one request at a time.
// Ports: clk, reset (async high), bus (lsu_ctrl_if.slave).
module lsu_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  lsu_ctrl_if.slave  bus
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  lsu_state_t  state;
  lsu_state_t  state_n;
  logic [2:0]  cnt;
  lsu_err_t    chk_err;
  logic        accept;
  logic        ld_q;

  logic [31:0] addr_q;
  mem_op_t     fun3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [4:0]  rd_q;
  logic        is_ld_q;
  lsu_err_t    err_q;

  lsu_align_check #(
    .DEPTH (DEPTH)
  ) u_chk (
    .op   (bus.req_op),
    .addr (bus.req_addr),
    .err  (chk_err)
  );

  assign accept = bus.req_valid && (state == S_IDLE);
  assign ld_q   = is_load(fun3_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (chk_err != ERR_OK) state_n = S_RESP;
          else                   state_n = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (ld_q && (RD_LAT != 0)) state_n = S_WAIT;
        else                       state_n = S_RESP;
      end
      S_WAIT: begin
        if (cnt == 3'd1) state_n = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so reset drops them at once.
  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.resp_valid = (state == S_RESP);
    bus.mem_read   = (state == S_ACCESS) && ld_q;
    bus.mem_write  = (state == S_ACCESS) && !ld_q;
  end

  // Memory pins only move on a clean accept, so faults
  // leave the last ACCESS values on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      fun3_q  <= LB;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      is_ld_q <= 1'b0;
      err_q   <= ERR_OK;
      cnt     <= '0;
    end else begin
      if (accept) begin
        rd_q    <= bus.req_rd;
        is_ld_q <= is_load(bus.req_op);
        err_q   <= chk_err;
        rdata_q <= '0;
        if (chk_err == ERR_OK) begin
          addr_q  <= bus.req_addr;
          fun3_q  <= bus.req_op;
          wdata_q <= bus.req_wdata;
        end
      end
      if ((state == S_ACCESS) && ld_q) begin
        if (RD_LAT == 0) rdata_q <= bus.mem_rdata;
        else             cnt     <= LAT;
      end
      if (state == S_WAIT) begin
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_fun3     = fun3_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_rd      = rd_q;
  assign bus.resp_is_load = is_ld_q;
  assign bus.resp_err     = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: RD_LAT=0 and RD_LAT=3 instances,
// directed + random ops checked against a byte-array model.
module tb_lsu_ctrl;
  import mem_pkg::*;

  localparam int DEPTH = 1024;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  mem_op_t     req_op = LB;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_ready = 1'b0;

  lsu_ctrl_if b0 ();
  lsu_ctrl_if b3 ();

  lsu_ctrl #(.DEPTH(DEPTH), .RD_LAT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (b0)
  );

  lsu_ctrl #(.DEPTH(DEPTH), .RD_LAT(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (b3)
  );

  assign b0.req_valid  = req_valid & ~sel;
  assign b3.req_valid  = req_valid & sel;
  assign b0.resp_ready = resp_ready & ~sel;
  assign b3.resp_ready = resp_ready & sel;
  assign b0.req_op     = req_op;
  assign b3.req_op     = req_op;
  assign b0.req_addr   = req_addr;
  assign b3.req_addr   = req_addr;
  assign b0.req_wdata  = req_wdata;
  assign b3.req_wdata  = req_wdata;
  assign b0.req_rd     = req_rd;
  assign b3.req_rd     = req_rd;

  logic        o_req_ready, o_resp_valid;
  logic        o_mem_read, o_mem_write;
  logic        o_is_load;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [4:0]  o_rd;
  mem_op_t     o_fun3;
  lsu_err_t    o_err;

  assign o_req_ready  = sel ? b3.req_ready    : b0.req_ready;
  assign o_resp_valid = sel ? b3.resp_valid   : b0.resp_valid;
  assign o_mem_read   = sel ? b3.mem_read     : b0.mem_read;
  assign o_mem_write  = sel ? b3.mem_write    : b0.mem_write;
  assign o_is_load    = sel ? b3.resp_is_load : b0.resp_is_load;
  assign o_rdata      = sel ? b3.resp_rdata   : b0.resp_rdata;
  assign o_mem_addr   = sel ? b3.mem_addr     : b0.mem_addr;
  assign o_mem_wdata  = sel ? b3.mem_wdata    : b0.mem_wdata;
  assign o_rd         = sel ? b3.resp_rd      : b0.resp_rd;
  assign o_fun3       = sel ? b3.mem_fun3     : b0.mem_fun3;
  assign o_err        = sel ? b3.resp_err     : b0.resp_err;

  // data_memory stand-ins: byte arrays, sized/extended reads.
  logic [7:0]  m0 [0:4095];
  logic [7:0]  m3 [0:4095];
  logic [11:0] a0, a3;
  logic [2:0]  k3;
  logic [31:0] raw3;

  function automatic logic [31:0] ext(
    mem_op_t f, logic [7:0] x0, logic [7:0] x1,
    logic [7:0] x2, logic [7:0] x3);
    case (f)
      LB:      return {{24{x0[7]}}, x0};
      LBU:     return {24'd0, x0};
      LH:      return {{16{x1[7]}}, x1, x0};
      LHU:     return {16'd0, x1, x0};
      default: return {x3, x2, x1, x0};
    endcase
  endfunction

  assign a0 = b0.mem_addr[11:0];
  assign a3 = b3.mem_addr[11:0];

  assign b0.mem_rdata = ext(b0.mem_fun3, m0[a0],
    m0[a0 + 12'd1], m0[a0 + 12'd2], m0[a0 + 12'd3]);
  assign raw3 = ext(b3.mem_fun3, m3[a3],
    m3[a3 + 12'd1], m3[a3 + 12'd2], m3[a3 + 12'd3]);
  assign b3.mem_rdata = (k3 >= 3'd3) ? raw3 : 32'hBAD;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) m0[i] <= 8'd0;
    end else if (b0.mem_write) begin
      m0[a0] <= b0.mem_wdata[7:0];
      if (b0.mem_fun3 != SB)
        m0[a0 + 12'd1] <= b0.mem_wdata[15:8];
      if (b0.mem_fun3 == SW) begin
        m0[a0 + 12'd2] <= b0.mem_wdata[23:16];
        m0[a0 + 12'd3] <= b0.mem_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4096; i++) m3[i] <= 8'd0;
    end else if (b3.mem_write) begin
      m3[a3] <= b3.mem_wdata[7:0];
      if (b3.mem_fun3 != SB)
        m3[a3 + 12'd1] <= b3.mem_wdata[15:8];
      if (b3.mem_fun3 == SW) begin
        m3[a3 + 12'd2] <= b3.mem_wdata[23:16];
        m3[a3 + 12'd3] <= b3.mem_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     k3 <= '0;
    else if (b3.mem_read)          k3 <= 3'd1;
    else if (k3 != 0 && k3 < 3'd7) k3 <= k3 + 3'd1;
  end

  // Reference model: flat byte memory updated on accepted stores.
  logic [7:0] rm [0:4095];

  task automatic ref_clear();
    for (int i = 0; i < 4096; i++) rm[i] = 8'd0;
  endtask

  function automatic logic [31:0] ref_load(
    mem_op_t op, logic [31:0] a);
    logic [7:0] x0, x1, x2, x3;
    x0 = rm[a[11:0]];
    x1 = rm[a[11:0] + 12'd1];
    x2 = rm[a[11:0] + 12'd2];
    x3 = rm[a[11:0] + 12'd3];
    case (op)
      LB:  return x0[7] ? 32'hFFFFFF00 | 32'(x0) : 32'(x0);
      LBU: return 32'(x0);
      LH:  return x1[7] ? 32'hFFFF0000 | 32'({x1, x0})
                        : 32'({x1, x0});
      LHU: return 32'({x1, x0});
      default: return {x3, x2, x1, x0};
    endcase
  endfunction

  task automatic chk(input string tag,
    input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
        tag, obs, exp);
    end
  endtask

  task automatic do_req(input mem_op_t op,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic [4:0] rd, input int stall);
    lsu_err_t    e;
    logic        ld, ok;
    int          lat, n, nrd, nwr;
    logic [31:0] exp_d;
    ld = (op == LB) || (op == LBU) || (op == LH) ||
         (op == LHU) || (op == LW);
    if (((op == LH || op == LHU || op == SH) && addr[0]) ||
        ((op == LW || op == SW) && addr[1:0] != 2'b00))
      e = ERR_MISALIGNED;
    else if (addr >= LIMIT)
      e = ERR_RANGE;
    else
      e = ERR_OK;
    ok = (e == ERR_OK);
    lat = !ok ? 1 : (ld ? 2 + (sel ? 3 : 0) : 2);
    exp_d = (ok && ld) ? ref_load(op, addr) : 32'd0;
    if (ok && !ld) begin
      rm[addr[11:0]] = wd[7:0];
      if (op != SB) rm[addr[11:0] + 12'd1] = wd[15:8];
      if (op == SW) begin
        rm[addr[11:0] + 12'd2] = wd[23:16];
        rm[addr[11:0] + 12'd3] = wd[31:24];
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wd;
    req_rd = rd;
    n = 0;
    while (!o_req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(o_req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    nrd = 0;
    nwr = 0;
    while (n <= 20) begin
      if (o_mem_read && o_mem_write)
        chk("strobe_excl", 32'd1, 32'd0);
      if (o_mem_read || o_mem_write) begin
        chk("mem_addr", o_mem_addr, addr);
        chk("mem_fun3", 32'(o_fun3), 32'(op));
        if (o_mem_write) chk("mem_wdata", o_mem_wdata, wd);
      end
      if (o_mem_read) nrd++;
      if (o_mem_write) nwr++;
      if (o_resp_valid) break;
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("n_read", 32'(nrd), 32'(ok && ld));
    chk("n_write", 32'(nwr), 32'(ok && !ld));
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) begin
        @(negedge clk);
        chk("hold_valid", 32'(o_resp_valid), 32'd1);
        chk("hold_ready", 32'(o_req_ready), 32'd0);
        chk("hold_strobe",
          32'(o_mem_read | o_mem_write), 32'd0);
      end
      chk("resp_rdata", o_rdata, exp_d);
      chk("resp_rd", 32'(o_rd), 32'(rd));
      chk("resp_is_load", 32'(o_is_load), 32'(ld));
      chk("resp_err", 32'(o_err), 32'(e));
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 32'(o_resp_valid), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    ref_clear();
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    ref_clear();
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_mem_read", 32'(b0.mem_read), 32'd0);
    chk("rst_mem_write", 32'(b0.mem_write), 32'd0);
    chk("rst_mem_addr", b0.mem_addr, 32'd0);
    chk("rst_mem_fun3", 32'(b0.mem_fun3), 32'd0);
    chk("rst_mem_wdata", b0.mem_wdata, 32'd0);
    chk("rst_rdata", b0.resp_rdata, 32'd0);
    chk("rst_err", 32'(b0.resp_err), 32'd0);
    chk("rst_is_load", 32'(b0.resp_is_load), 32'd0);
    chk("rst_rd", 32'(b0.resp_rd), 32'd0);
    reset = 1'b0;

    do_req(SW, 32'h10, 32'hDEADBEEF, 5'd1, 0);
    do_req(LW, 32'h10, 32'h0, 5'd2, 0);
    do_req(LH, 32'h13, 32'h0, 5'd3, 0);
    do_req(LW, 32'h1000, 32'h0, 5'd4, 0);
    do_req(SW, 32'h12, 32'h1, 5'd5, 0);
    do_req(SB, 32'h11, 32'hAB, 5'd6, 0);
    do_req(LBU, 32'h11, 32'h0, 5'd7, 0);
    do_req(LB, 32'h11, 32'h0, 5'd8, 0);
    do_req(SW, 32'hFFC, 32'hCAFEF00D, 5'd9, 0);
    do_req(LH, 32'hFFE, 32'h0, 5'd10, 0);
    do_req(LW, 32'h10, 32'h0, 5'd11, 5);

    for (int i = 0; i < 40; i++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h1000 + $urandom_range(0, 255);
      else if (r == 1) a = 32'hFFFFFFFC;
      else             a = 32'($urandom_range(0, 63));
      do_req(mem_op_t'($urandom_range(0, 7)), a, $urandom,
        5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end

    sel = 1'b1;
    pulse_reset();
    do_req(SW, 32'h40, 32'h1234, 5'd12, 0);
    do_req(LW, 32'h40, 32'h0, 5'd13, 0);
    do_req(LHU, 32'h40, 32'h0, 5'd14, 2);
    do_req(LH, 32'h41, 32'h0, 5'd15, 0);

    @(negedge clk);
    req_valid = 1'b1;
    req_op = LW;
    req_addr = 32'h20;
    req_rd = 5'd16;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("t6_access_read", 32'(o_mem_read), 32'd1);
    @(posedge clk);
    #2;
    chk("t6_wait_read", 32'(o_mem_read), 32'd0);
    reset = 1'b1;
    #1;
    chk("t6_rst_read", 32'(o_mem_read), 32'd0);
    chk("t6_rst_write", 32'(o_mem_write), 32'd0);
    chk("t6_rst_valid", 32'(o_resp_valid), 32'd0);
    chk("t6_rst_fun3", 32'(o_fun3), 32'd0);
    chk("t6_rst_addr", o_mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    ref_clear();
    reset = 1'b0;
    do_req(SW, 32'h20, 32'h5A5A0001, 5'd17, 0);
    do_req(LW, 32'h20, 32'h0, 5'd18, 0);

    for (int i = 0; i < 10; i++) begin
      do_req(mem_op_t'($urandom_range(0, 7)),
        32'($urandom_range(0, 31)), $urandom,
        5'($urandom_range(0, 31)), $urandom_range(0, 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
